// File: rtl/tim_mux_scan_ctrl.sv
// tim_mux_scan_ctrl: drives an external select mux through every source,
// lets each source settle for a programmable number of cycles, samples the
// mux output and presents all samples plus their sum as one valid/ready packet.
module tim_mux_scan_ctrl #(
   parameter int WIDTH       = 8,
   parameter int NUM_SRC     = 3,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   output logic                       busy,
   output logic [1:0]                 sel,
   input  logic [WIDTH-1:0]           result,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH*NUM_SRC-1:0]   out_data,
   output logic [WIDTH+1:0]           out_sum
);

   // Settle counter only ever holds HOLD_CYCLES-1 down to 0.
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD   = CW'(HOLD_CYCLES - 1);
   localparam logic [1:0]    LAST_SEL = 2'(NUM_SRC - 1);
   // sel parks here while idle so the mux sits on its default path.
   localparam logic [1:0]    PARK_SEL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Scan sequencer: every output is registered; reset beats abort beats start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         sel       <= PARK_SEL;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sum   <= '0;
         cnt       <= '0;
      end else if (abort) begin
         // Captured slots and sum are left in place but never presented.
         state     <= S_IDLE;
         sel       <= PARK_SEL;
         busy      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_SETTLE;
                  sel      <= '0;
                  cnt      <= RELOAD;
                  busy     <= 1'b1;
                  out_data <= '0;
                  out_sum  <= '0;
               end
            end

            S_SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  state <= S_SAMPLE;
               end
            end

            S_SAMPLE: begin
               for (int unsigned i = 0; i < NUM_SRC; i++) begin
                  if (sel == 2'(i)) begin
                     out_data[i*WIDTH +: WIDTH] <= result;
                  end
               end
               out_sum <= out_sum + {2'b00, result};
               if (sel == LAST_SEL) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
               end else begin
                  state <= S_SETTLE;
                  sel   <= sel + 2'd1;
                  cnt   <= RELOAD;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  sel       <= PARK_SEL;
                  busy      <= 1'b0;
                  out_valid <= 1'b0;
               end
            end

            default: begin
               state     <= S_IDLE;
               sel       <= PARK_SEL;
               busy      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tim_mux_scan_ctrl.sv
// tb_tim_mux_scan_ctrl: directed and randomized scans of two controller
// configurations (3 sources / 1 settle cycle and 4 sources / 3 settle cycles).
module tb_tim_mux_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;

   logic        start_a, abort_a, ready_a;
   logic        busy_a, valid_a;
   logic [1:0]  sel_a;
   logic [7:0]  res_a;
   logic [23:0] data_a;
   logic [9:0]  sum_a;
   logic [7:0]  mva [4];

   logic        start_b, abort_b, ready_b;
   logic        busy_b, valid_b;
   logic [1:0]  sel_b;
   logic [7:0]  res_b;
   logic [31:0] data_b;
   logic [9:0]  sum_b;
   logic [7:0]  mvb [4];

   int ntests = 0;
   int nfail  = 0;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Combinational source muxes; entry 3 is the default/else path.
   assign res_a = mva[sel_a];
   assign res_b = mvb[sel_b];

   tim_mux_scan_ctrl #(.WIDTH(8), .NUM_SRC(3), .HOLD_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .busy(busy_a), .sel(sel_a), .result(res_a),
      .out_valid(valid_a), .out_ready(ready_a),
      .out_data(data_a), .out_sum(sum_a)
   );

   tim_mux_scan_ctrl #(.WIDTH(8), .NUM_SRC(4), .HOLD_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .busy(busy_b), .sel(sel_b), .result(res_b),
      .out_valid(valid_b), .out_ready(ready_b),
      .out_data(data_b), .out_sum(sum_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference packet: slot i is the mux value for source i, sum is plain addition.
   task automatic model_a(output logic [63:0] ed, output logic [63:0] es);
      ed = '0;
      es = '0;
      for (int i = 0; i < 3; i++) begin
         ed = ed | (64'(mva[i]) << (8 * i));
         es = es + 64'(mva[i]);
      end
   endtask

   // One full scan on dut_a, holding off out_ready for bp cycles once valid.
   task automatic scan_a(input int bp);
      logic [63:0] ed, es;
      model_a(ed, es);
      ready_a = (bp == 0);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      // Each source occupies 2 cycles; valid must stay low for all 6.
      for (int k = 0; k < 6; k++) begin
         check("a_scan_sel", sel_a, 64'(k / 2));
         check("a_scan_busy", busy_a, 1);
         check("a_scan_valid_low", valid_a, 0);
         if (k == 2) start_a = 1'b1;   // start while busy must be ignored
         tick();
         start_a = 1'b0;
      end
      check("a_valid_rise", valid_a, 1);
      check("a_data", data_a, ed);
      check("a_sum", sum_a, es);
      check("a_done_busy", busy_a, 1);
      check("a_done_sel", sel_a, 2);
      for (int k = 0; k < bp; k++) begin
         start_a = (k % 2 == 1);
         tick();
         check("a_bp_valid", valid_a, 1);
         check("a_bp_data", data_a, ed);
         check("a_bp_sum", sum_a, es);
         check("a_bp_busy", busy_a, 1);
      end
      ready_a = 1'b1;
      start_a = (bp != 0);           // start coinciding with handshake is ignored
      tick();
      start_a = 1'b0;
      check("a_hs_valid", valid_a, 0);
      check("a_hs_busy", busy_a, 0);
      check("a_hs_sel", sel_a, 3);
      check("a_hold_data", data_a, ed);
      check("a_hold_sum", sum_a, es);
      tick();
      check("a_idle_after_hs", busy_a, 0);
   endtask

   initial begin
      bit seen_valid;
      rst = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
      start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
      mva[0] = 8'h11; mva[1] = 8'h22; mva[2] = 8'h33; mva[3] = 8'hA5;
      mvb[0] = 8'h5A; mvb[1] = 8'hC3; mvb[2] = 8'h7E; mvb[3] = 8'h00;
      start_a = 1'b1;                  // rst has priority over start
      tick();
      tick();
      start_a = 1'b0;
      check("rst_sel", sel_a, 3);
      check("rst_busy", busy_a, 0);
      check("rst_valid", valid_a, 0);
      check("rst_data", data_a, 0);
      check("rst_sum", sum_a, 0);
      check("rst_sel_b", sel_b, 3);
      rst = 1'b0;
      tick();

      // Basic scan with ready held high, then saturating values with backpressure.
      scan_a(0);
      check("a_pkt_const", data_a, 64'h332211);
      check("a_sum_const", sum_a, 64'h066);
      mva[0] = 8'hFF; mva[1] = 8'hFF; mva[2] = 8'hFF;
      scan_a(10);
      check("a_max_sum_const", sum_a, 64'h2FD);

      // Randomized source values and backpressure lengths.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 3; i++) mva[i] = 8'($urandom_range(0, 255));
         scan_a(int'($urandom_range(0, 3)));
      end

      // Abort during the second settle phase.
      mva[0] = 8'h11; mva[1] = 8'h22; mva[2] = 8'h33;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      check("ab_pre_sel", sel_a, 1);
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check("ab_sel", sel_a, 3);
      check("ab_busy", busy_a, 0);
      check("ab_valid", valid_a, 0);
      seen_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (valid_a) seen_valid = 1'b1;
      end
      check("ab_never_valid", seen_valid, 0);
      abort_a = 1'b1;
      start_a = 1'b1;
      tick();
      abort_a = 1'b0;
      start_a = 1'b0;
      check("ab_start_busy", busy_a, 0);
      check("ab_start_sel", sel_a, 3);
      scan_a(0);

      // Reset while sampling source 1.
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      tick();
      tick();
      check("mr_pre_sel", sel_a, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_sel", sel_a, 3);
      check("mr_busy", busy_a, 0);
      check("mr_valid", valid_a, 0);
      check("mr_data", data_a, 0);
      check("mr_sum", sum_a, 0);
      tick();

      // Four sources with three settle cycles: each sel held 4 cycles, valid at 16.
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check("b_scan_sel", sel_b, 64'(k / 4));
         check("b_scan_valid_low", valid_b, 0);
         tick();
      end
      check("b_valid_rise", valid_b, 1);
      check("b_data", data_b, 64'h007EC35A);
      check("b_slot3", data_b[31:24], 0);
      check("b_sum", sum_b, 64'h19B);
      tick();
      check("b_valid_one_cycle", valid_b, 0);
      check("b_idle_sel", sel_b, 3);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
